// File: rtl/divider.sv
// Unsigned restoring divider: one quotient bit per clock, MSB first.
// Capture in IDLE, WIDTH trial-subtract steps in CALC, result publish in DONE.
module divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             val,
  output logic             div_zero,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  // dvd_q starts as the dividend and is shifted into the quotient bit by bit.
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] prem_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             trial_ok;

  // One restoring step: shift in the next dividend bit, then trial-subtract.
  always_comb begin
    shifted  = {prem_q, dvd_q[WIDTH-1]};
    trial    = shifted - {1'b0, dvs_q};
    // shifted < 2*divisor, so bit WIDTH is set exactly when the difference is negative.
    trial_ok = ~trial[WIDTH];
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (en) begin
          state_d = (op2 == '0) ? DONE : CALC;
        end
      end
      CALC: begin
        if (cnt_q == LAST) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand capture, iteration datapath and registered result publish.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_q    <= '0;
      dvs_q    <= '0;
      prem_q   <= '0;
      cnt_q    <= '0;
      quot     <= '0;
      rem      <= '0;
      val      <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      val <= 1'b0;
      case (state_q)
        IDLE: begin
          if (en) begin
            dvd_q  <= op1;
            dvs_q  <= op2;
            prem_q <= '0;
            cnt_q  <= '0;
          end
        end
        CALC: begin
          prem_q <= trial_ok ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
          dvd_q  <= (dvd_q << 1) | WIDTH'(trial_ok);
          cnt_q  <= cnt_q + CW'(1);
        end
        DONE: begin
          val <= 1'b1;
          if (dvs_q == '0) begin
            // dvd_q was never shifted on this path, so it still holds op1.
            quot     <= '1;
            rem      <= dvd_q;
            div_zero <= 1'b1;
          end else begin
            quot     <= dvd_q;
            rem      <= prem_q;
            div_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: directed cases, timing, abort, randomized model check.
module tb_divider;

  localparam int W = 32;
  localparam logic [W-1:0] ONES = '1;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic [W-1:0] op1;
  logic [W-1:0] op2;
  logic [W-1:0] quot;
  logic [W-1:0] rem;
  logic         val;
  logic         div_zero;
  logic         busy;

  int tests;
  int fails;

  divider #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .op1      (op1),
    .op2      (op2),
    .quot     (quot),
    .rem      (rem),
    .val      (val),
    .div_zero (div_zero),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain arithmetic, with the divide-by-zero convention.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] q, output logic [W-1:0] r,
                                output logic dz);
    if (b == '0) begin
      q  = ONES;
      r  = a;
      dz = 1'b1;
    end else begin
      q  = a / b;
      r  = a % b;
      dz = 1'b0;
    end
  endfunction

  // Start one operation, scramble the operand inputs after capture, and wait
  // for val. lat = edges after the capture edge, or -1 on timeout.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
    lat = -1;
    @(negedge clk);
    op1 = a;
    op2 = b;
    en  = 1'b1;
    @(posedge clk);
    #1;
    en  = 1'b0;
    op1 = $urandom;
    op2 = $urandom;
    for (int i = 1; i <= 3 * W; i++) begin
      @(posedge clk);
      #1;
      if (val) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    en    = 1'b1;
    op1   = 32'd10;
    op2   = 32'd3;
    #3;
    tests++;
    if ({quot, rem, val, div_zero, busy} !== '0) begin
      fails++;
      $display("FAIL reset_async: got quot=%h rem=%h val=%b dz=%b busy=%b want all 0",
               quot, rem, val, div_zero, busy);
    end
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({val, busy} !== 2'b00) begin
      fails++;
      $display("FAIL reset_hold: got val=%b busy=%b want 0 0", val, busy);
    end
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed;
    logic [W-1:0] a[5];
    logic [W-1:0] b[5];
    logic [W-1:0] eq[5];
    logic [W-1:0] er[5];
    int lat;
    a = '{32'd405, 32'd100, 32'd5, ONES, ONES};
    b = '{32'd15, 32'd7, 32'd9, 32'd1, ONES};
    eq = '{32'd27, 32'd14, 32'd0, ONES, 32'd1};
    er = '{32'd0, 32'd2, 32'd5, 32'd0, 32'd0};
    for (int i = 0; i < 5; i++) begin
      do_op(a[i], b[i], lat);
      tests++;
      if (lat != W + 1) begin
        fails++;
        $display("FAIL dir_latency[%0d]: got %0d want %0d", i, lat, W + 1);
      end
      tests++;
      if ({quot, rem, div_zero} !== {eq[i], er[i], 1'b0}) begin
        fails++;
        $display("FAIL dir_result[%0d] %0d/%0d: got q=%h r=%h dz=%b want q=%h r=%h dz=0",
                 i, a[i], b[i], quot, rem, div_zero, eq[i], er[i]);
      end
      @(posedge clk);
      #1;
      tests++;
      if ({val, busy, quot, rem} !== {2'b00, eq[i], er[i]}) begin
        fails++;
        $display("FAIL dir_pulse_hold[%0d]: got val=%b busy=%b q=%h r=%h", i, val, busy,
                 quot, rem);
      end
    end
  endtask

  task automatic test_div_zero;
    int lat;
    do_op(32'd1234, 32'd0, lat);
    tests++;
    if (lat != 1) begin
      fails++;
      $display("FAIL dz_latency: got %0d want 1", lat);
    end
    tests++;
    if ({quot, rem, div_zero} !== {ONES, 32'd1234, 1'b1}) begin
      fails++;
      $display("FAIL dz_result: got q=%h r=%0d dz=%b want q=%h r=1234 dz=1", quot, rem,
               div_zero, ONES);
    end
    @(posedge clk);
    #1;
    tests++;
    if ({val, div_zero} !== 2'b01) begin
      fails++;
      $display("FAIL dz_pulse: got val=%b dz=%b want val=0 dz=1", val, div_zero);
    end
    do_op(32'd100, 32'd7, lat);
    tests++;
    if ({lat == W + 1, quot, rem, div_zero} !== {1'b1, 32'd14, 32'd2, 1'b0}) begin
      fails++;
      $display("FAIL dz_clear: got lat=%0d q=%0d r=%0d dz=%b want lat=%0d 14/2 dz=0", lat,
               quot, rem, div_zero, W + 1);
    end
  endtask

  task automatic test_ignore_en;
    int nval;
    logic busy_seen;
    nval = 0;
    busy_seen = 1'b1;
    @(negedge clk);
    op1 = 32'd405;
    op2 = 32'd15;
    en  = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      busy_seen &= busy;
    end
    op1 = 32'd9;
    op2 = 32'd3;
    en  = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b0;
    for (int i = 0; i < 3 * W; i++) begin
      @(posedge clk);
      #1;
      if (val) begin
        nval++;
        tests++;
        if ({quot, rem} !== {32'd27, 32'd0}) begin
          fails++;
          $display("FAIL ign_result: got q=%0d r=%0d want 27/0", quot, rem);
        end
      end
    end
    tests++;
    if (nval != 1) begin
      fails++;
      $display("FAIL ign_val_count: got %0d want 1", nval);
    end
    tests++;
    if ({busy_seen, busy} !== 2'b10) begin
      fails++;
      $display("FAIL ign_busy: got busy_in_calc=%b busy_after=%b want 1 0", busy_seen, busy);
    end
  endtask

  task automatic test_reset_mid;
    int nval;
    int lat;
    nval = 0;
    @(negedge clk);
    op1 = 32'd100;
    op2 = 32'd7;
    en  = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (val) nval++;
    end
    #1;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({quot, rem, val, div_zero, busy} !== '0) begin
      fails++;
      $display("FAIL mid_reset_async: got q=%h r=%h val=%b dz=%b busy=%b want all 0", quot,
               rem, val, div_zero, busy);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2 * W; i++) begin
      @(posedge clk);
      #1;
      if (val) nval++;
    end
    tests++;
    if (nval != 0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset_noval: got vals=%0d busy=%b want 0 0", nval, busy);
    end
    do_op(32'd100, 32'd7, lat);
    tests++;
    if ({lat == W + 1, quot, rem} !== {1'b1, 32'd14, 32'd2}) begin
      fails++;
      $display("FAIL mid_reset_after: got lat=%0d q=%0d r=%0d want lat=%0d 14/2", lat, quot,
               rem, W + 1);
    end
  endtask

  task automatic test_random;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic dz;
    int lat;
    for (int n = 0; n < 40; n++) begin
      a = $urandom >> $urandom_range(0, 31);
      b = (n % 10 == 3) ? '0 : ($urandom >> $urandom_range(0, 31));
      model(a, b, q, r, dz);
      do_op(a, b, lat);
      tests++;
      if (lat != (dz ? 1 : W + 1) || {quot, rem, div_zero} !== {q, r, dz}) begin
        fails++;
        $display("FAIL rand[%0d] %h/%h: got lat=%0d q=%h r=%h dz=%b want q=%h r=%h dz=%b",
                 n, a, b, lat, quot, rem, div_zero, q, r, dz);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic dz;
    int cnt;
    @(negedge clk);
    en = 1'b1;
    for (int n = 0; n < 4; n++) begin
      a  = $urandom;
      b  = ($urandom >> $urandom_range(0, 28)) | 32'd1;
      op1 = a;
      op2 = b;
      model(a, b, q, r, dz);
      cnt = -1;
      for (int i = 1; i <= 3 * W; i++) begin
        @(posedge clk);
        #1;
        if (val) begin
          cnt = i;
          break;
        end
      end
      tests++;
      if (cnt != W + 2 || {quot, rem, div_zero} !== {q, r, dz}) begin
        fails++;
        $display("FAIL b2b[%0d]: got period=%0d q=%h r=%h want period=%0d q=%h r=%h", n, cnt,
                 quot, rem, W + 2, q, r);
      end
    end
    en = 1'b0;
    repeat (W + 4) @(posedge clk);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    en    = 1'b0;
    op1   = '0;
    op2   = '0;
    test_reset();
    test_directed();
    test_div_zero();
    test_ignore_en();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
